fsm_seq_gen: RTL

//   Serial pattern transmitter: the driving end of the E -> FSM_C sequence-detector link.

---
 rtl/fsm_seq_gen.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fsm_seq_gen.sv
// Serial pattern transmitter: shifts a latched WIDTH-bit pattern out MSB-first,
// REPEAT+1 times with GAP idle cycles between copies, then pulses DONE.
module fsm_seq_gen #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic [WIDTH-1:0] PATTERN,
  input  logic [CNT_W-1:0] REPEAT,
  output logic             SOUT,
  output logic             SVALID,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned BitW = $clog2(WIDTH);
  localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StGap, StFin} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   pat_q, pat_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   rep_q, rep_d;
  logic [CNT_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0]    gap_cnt_q, gap_cnt_d;
  logic               sout_q, sout_d;
  logic               svalid_q, svalid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    shreg_d   = shreg_q;
    rep_d     = rep_q;
    rep_cnt_d = rep_cnt_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    // Outputs default to idle; each state re-asserts what it drives.
    sout_d    = 1'b0;
    svalid_d  = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (START && !ABORT) begin
          pat_d     = PATTERN;
          rep_d     = REPEAT;
          rep_cnt_d = '0;
          shreg_d   = PATTERN;
          bit_cnt_d = BitW'(WIDTH - 1);
          state_d   = StShift;
          sout_d    = PATTERN[WIDTH-1];
          svalid_d  = 1'b1;
          busy_d    = 1'b1;
        end
      end

      StShift: begin
        if (ABORT) begin
          state_d = StIdle;
        end else if (bit_cnt_q != '0) begin
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q - BitW'(1);
          sout_d    = shreg_q[WIDTH-2];
          svalid_d  = 1'b1;
          busy_d    = 1'b1;
        end else if (rep_cnt_q < rep_q) begin
          rep_cnt_d = rep_cnt_q + CNT_W'(1);
          if (GAP == 0) begin
            shreg_d   = pat_q;
            bit_cnt_d = BitW'(WIDTH - 1);
            sout_d    = pat_q[WIDTH-1];
            svalid_d  = 1'b1;
            busy_d    = 1'b1;
          end else begin
            state_d   = StGap;
            gap_cnt_d = GapW'(GAP - 1);
            busy_d    = 1'b1;
          end
        end else begin
          state_d = StFin;
          done_d  = 1'b1;
        end
      end

      StGap: begin
        if (ABORT) begin
          state_d = StIdle;
        end else if (gap_cnt_q == '0) begin
          state_d   = StShift;
          shreg_d   = pat_q;
          bit_cnt_d = BitW'(WIDTH - 1);
          sout_d    = pat_q[WIDTH-1];
          svalid_d  = 1'b1;
          busy_d    = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GapW'(1);
          busy_d    = 1'b1;
        end
      end

      StFin: begin
        // DONE was raised on entry; START and ABORT have no effect here.
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      pat_q     <= '0;
      shreg_q   <= '0;
      rep_q     <= '0;
      rep_cnt_q <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      sout_q    <= 1'b0;
      svalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      shreg_q   <= shreg_d;
      rep_q     <= rep_d;
      rep_cnt_q <= rep_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      sout_q    <= sout_d;
      svalid_q  <= svalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign SOUT   = sout_q;
  assign SVALID = svalid_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule
